// File: rtl/nios_key_pio_in.sv
// ---------------------------------------------------------------------------
// nios_key_pio_in
// Avalon-MM slave input PIO for push-buttons and switches. Each input bit is
// passed through a 2-flop synchroniser and a per-bit debouncer. Debounced
// edges of the selected polarity are latched into a sticky edgecapture
// register. A level interrupt is raised while any captured edge is unmasked.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address: 0 data, 1 reserved, 2 irqmask, 3 edgecapture
//   chipselect  slave select (qualifies writes only)
//   write_n     active-low write strobe
//   writedata   write data (irqmask load / edgecapture write-1-to-clear)
//   in_port     raw asynchronous external inputs
//   readdata    combinational read data, zero-extended from WIDTH
//   irq         level interrupt = |(edgecapture & irqmask)
// ---------------------------------------------------------------------------
module nios_key_pio_in #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 1,
   parameter int IDLE_LEVEL      = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;
   logic [WIDTH-1:0] debounced;
   logic [WIDTH-1:0] db_d_reg;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] irqmask_reg;
   logic [WIDTH-1:0] edgecapture_reg;
   logic [WIDTH-1:0] edgecapture_next;
   logic             wr_en;

   assign wr_en = chipselect & ~write_n;

   // Only the low WIDTH bits of writedata carry meaning.
   logic unused_wdata;
   assign unused_wdata = ^writedata;

   // Two-flop synchroniser; sync2_reg is the only copy used downstream.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_reg <= IDLE_VEC;
         sync2_reg <= IDLE_VEC;
      end else begin
         sync1_reg <= in_port;
         sync2_reg <= sync1_reg;
      end
   end

   // Per-bit debouncer: a change is accepted only after DEBOUNCE_CYCLES
   // consecutive synced samples that differ from the current debounced value.
   // Any sample matching the debounced value restarts the count.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
         logic [CNT_W-1:0] cnt_reg;
         logic             db_bit_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_reg    <= '0;
               db_bit_reg <= IDLE_VEC[gi];
            end else if (sync2_reg[gi] == db_bit_reg) begin
               cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
               db_bit_reg <= sync2_reg[gi];
               cnt_reg    <= '0;
            end else begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end

         assign debounced[gi] = db_bit_reg;
      end
   endgenerate

   // Delayed copy of the debounced value for edge detection. Reset to the
   // idle level so leaving reset never looks like an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_d_reg <= IDLE_VEC;
      end else begin
         db_d_reg <= debounced;
      end
   end

   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign edge_det = debounced & ~db_d_reg;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign edge_det = ~debounced & db_d_reg;
      end else begin : g_any
         assign edge_det = debounced ^ db_d_reg;
      end
   endgenerate

   // Write-1-to-clear, with a newly detected edge taking priority over a
   // clear of the same bit so no edge is lost.
   always_comb begin
      edgecapture_next = edgecapture_reg;
      if (wr_en && (address == 2'd3)) begin
         edgecapture_next = edgecapture_reg & ~writedata[WIDTH-1:0];
      end
      edgecapture_next = edgecapture_next | edge_det;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask_reg     <= '0;
         edgecapture_reg <= '0;
      end else begin
         edgecapture_reg <= edgecapture_next;
         if (wr_en && (address == 2'd2)) begin
            irqmask_reg <= writedata[WIDTH-1:0];
         end
      end
   end

   // Reads ignore chipselect, matching the companion output PIOs.
   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = debounced;
         2'd2:    readdata[WIDTH-1:0] = irqmask_reg;
         2'd3:    readdata[WIDTH-1:0] = edgecapture_reg;
         default: readdata = '0;
      endcase
   end

   assign irq = |(edgecapture_reg & irqmask_reg);

endmodule
